fft_bram_power_reader: RTL and testbench

Downstream consumer of the FFT capture BRAM. On a frame-ready pulse it reads one complete 8-microphone × 256-bin spectrum through BRAM port B and transposes it from bin-major to mic-major order. For each sample it computes the power re²+im² and streams the result on AXI-Stream with per-mic `tlast`. It sits between the FFT-to-BRAM writer (port A) and the beamforming/feature stage.

---
 rtl/fft_bram_power_reader.sv | 230 +++++++++++++++++++++++
 tb/tb_fft_bram_power_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bram_power_reader.sv
// fft_bram_power_reader
//
// Reads one complete spectrum frame (N_MICS x N_BINS complex samples) from the
// capture BRAM through port B when frame_start is pulsed. Samples are stored
// bin-major and read back mic-major. Each sample's power re^2 + im^2 is
// computed in a two-stage pipeline and streamed out through a small FIFO on
// AXI-Stream, with tlast marking the final bin of each mic.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   frame_start          one-cycle pulse: a new frame is available in the BRAM
//   bram_addr/en/rst     port-B byte address, read enable, reset (= ~rst_n)
//   bram_dout_re/im      port-B read data, sign-extended 24-bit values
//   m_axis_*             power stream: tdata = power, tuser = {mic, bin}
//   busy                 frame in progress (start accepted .. last beat taken)
//   frame_done           one-cycle pulse after the last beat is accepted
//   overrun              sticky: frame_start seen while a frame was active
//
// Handshake: a beat transfers on every rising edge where m_axis_tvalid and
// m_axis_tready are both high. Once tvalid rises, tdata/tuser/tlast stay
// stable and tvalid stays high until that transfer; tvalid never waits on
// tready.
module fft_bram_power_reader #(
    parameter int N_BINS     = 256,
    parameter int N_MICS     = 8,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    output logic [31:0] bram_addr,
    output logic        bram_en,
    output logic        bram_rst,
    input  logic [31:0] bram_dout_re,
    input  logic [31:0] bram_dout_im,
    output logic [47:0] m_axis_tdata,
    output logic [10:0] m_axis_tuser,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]    mic_cnt;
    logic [7:0]    bin_cnt;
    logic [31:0]   word_idx;
    logic [31:0]   cur_addr;
    logic [31:0]   addr_q;
    logic [11:0]   tag_in;          // {tlast, mic, bin}
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] in_flight;       // issued reads not yet written to the FIFO
    logic          issue, last_issue, push, pop;

    // Read-latency pipe carrying valid and tag next to the BRAM access
    logic [RD_LAT-1:0] rd_v;
    logic [11:0]       rd_tag [RD_LAT];

    // Arithmetic stages
    logic signed [23:0] re_s, im_s;
    logic signed [47:0] re_prod, im_prod;
    logic               s1_v, s2_v;
    logic [11:0]        s1_tag, s2_tag;
    logic [46:0]        re_sq, im_sq;
    logic [47:0]        s2_sum;

    // Output FIFO
    logic [47:0]   mem_data [FIFO_DEPTH];
    logic [11:0]   mem_tag  [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    logic unused_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit uses registered occupancy: every issued read already owns a FIFO
    // slot, so the FIFO can never overflow. A popped slot becomes reusable in
    // the following cycle.
    assign issue      = (state == RUN) && ((fifo_count + in_flight) < CW'(FIFO_DEPTH));
    assign last_issue = issue && (mic_cnt == 3'(N_MICS - 1)) && (bin_cnt == 8'(N_BINS - 1));
    assign push       = s2_v;
    assign pop        = m_axis_tvalid && m_axis_tready;

    assign word_idx = 32'(bin_cnt) * 32'(N_MICS) + 32'(mic_cnt);
    assign cur_addr = {word_idx[29:0], 2'b00};
    assign tag_in   = {bin_cnt == 8'(N_BINS - 1), mic_cnt, bin_cnt};

    assign bram_en   = issue;
    assign bram_addr = issue ? cur_addr : addr_q;
    assign bram_rst  = ~rst_n;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            // Leave on the edge that takes the final beat so frame_done lands
            // in the very next cycle.
            DRAIN:   if (in_flight == '0 && fifo_count == CW'(1) && pop) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            RUN, DRAIN: busy       = 1'b1;
            DONE:       frame_done = 1'b1;
            default:    ;
        endcase
    end

    // Counters, held address, credit bookkeeping, overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mic_cnt   <= '0;
            bin_cnt   <= '0;
            addr_q    <= '0;
            in_flight <= '0;
            overrun   <= 1'b0;
        end else begin
            if (state == IDLE && frame_start) begin
                mic_cnt <= '0;
                bin_cnt <= '0;
            end else if (issue) begin
                addr_q <= cur_addr;
                if (bin_cnt == 8'(N_BINS - 1)) begin
                    bin_cnt <= '0;
                    mic_cnt <= mic_cnt + 3'd1;
                end else begin
                    bin_cnt <= bin_cnt + 8'd1;
                end
            end
            in_flight <= in_flight + CW'(issue) - CW'(push);
            if (frame_start && state != IDLE) overrun <= 1'b1;
        end
    end

    // Valid/tag delay matching the BRAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v <= '0;
            for (int i = 0; i < RD_LAT; i++) rd_tag[i] <= '0;
        end else begin
            rd_v[0]   <= issue;
            rd_tag[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_v[i]   <= rd_v[i-1];
                rd_tag[i] <= rd_tag[i-1];
            end
        end
    end

    // A 24-bit signed square is at most 2^46, so 47 unsigned bits hold it
    // and the 48-bit sum cannot wrap even at re = im = -2^23.
    assign re_s    = signed'(bram_dout_re[23:0]);
    assign im_s    = signed'(bram_dout_im[23:0]);
    assign re_prod = re_s * re_s;
    assign im_prod = im_s * im_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_tag <= '0;
            re_sq  <= '0;
            im_sq  <= '0;
            s2_v   <= 1'b0;
            s2_tag <= '0;
            s2_sum <= '0;
        end else begin
            s1_v   <= rd_v[RD_LAT-1];
            s1_tag <= rd_tag[RD_LAT-1];
            re_sq  <= re_prod[46:0];
            im_sq  <= im_prod[46:0];
            s2_v   <= s1_v;
            s2_tag <= s1_tag;
            s2_sum <= {1'b0, re_sq} + {1'b0, im_sq};
        end
    end

    // Output FIFO; storage is cleared on reset so idle outputs read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_tag[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= s2_sum;
                mem_tag[wr_ptr]  <= s2_tag;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    assign m_axis_tvalid = (fifo_count != '0);
    assign m_axis_tdata  = mem_data[rd_ptr];
    assign m_axis_tuser  = mem_tag[rd_ptr][10:0];
    assign m_axis_tlast  = mem_tag[rd_ptr][11];

    assign unused_bits = ^{bram_dout_re[31:24], bram_dout_im[31:24],
                           re_prod[47], im_prod[47], word_idx[31:30]};

endmodule

// File: tb/tb_fft_bram_power_reader.sv
// Testbench for fft_bram_power_reader: BRAM port-B model, directed frames
// with hand-computed powers, scoreboard queue and a single summary line.
module tb_fft_bram_power_reader;

    localparam int N_BINS     = 256;
    localparam int N_MICS     = 8;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int N_BEATS    = N_BINS * N_MICS;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic [31:0] bram_addr;
    logic        bram_en;
    logic        bram_rst;
    logic [31:0] bram_dout_re;
    logic [31:0] bram_dout_im;
    logic [47:0] m_axis_tdata;
    logic [10:0] m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    fft_bram_power_reader #(
        .N_BINS(N_BINS), .N_MICS(N_MICS), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_rst(bram_rst),
        .bram_dout_re(bram_dout_re), .bram_dout_im(bram_dout_im),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- BRAM port-B model ----------------
    logic [31:0] re_mem [N_BEATS];
    logic [31:0] im_mem [N_BEATS];
    logic [31:0] rd_re  [RD_LAT];
    logic [31:0] rd_im  [RD_LAT];

    always @(posedge clk) begin
        if (bram_en) begin
            rd_re[0] <= re_mem[bram_addr[12:2]];
            rd_im[0] <= im_mem[bram_addr[12:2]];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            rd_re[i] <= rd_re[i-1];
            rd_im[i] <= rd_im[i-1];
        end
    end
    assign bram_dout_re = rd_re[RD_LAT-1];
    assign bram_dout_im = rd_im[RD_LAT-1];

    // ---------------- scoreboard ----------------
    logic [59:0] exp_q[$];   // {tlast, mic[2:0], bin[7:0], power[47:0]}
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: re = b+1, im = m
    // mode 1: re = -(b+1), im = -m, with three corner samples on mic 0
    task automatic load_frame(input int mode);
        logic [47:0] d;
        exp_q.delete();
        for (int b = 0; b < N_BINS; b++) begin
            for (int m = 0; m < N_MICS; m++) begin
                re_mem[b*N_MICS+m] = (mode == 0) ? 32'(b + 1) : 32'(-(b + 1));
                im_mem[b*N_MICS+m] = (mode == 0) ? 32'(m)     : 32'(-m);
            end
        end
        if (mode == 1) begin
            re_mem[0]  = 32'hFF80_0000;  im_mem[0]  = 32'hFF80_0000;
            re_mem[8]  = 32'h007F_FFFF;  im_mem[8]  = 32'h0000_0000;
            re_mem[16] = 32'hFFFF_FFFF;  im_mem[16] = 32'hFFFF_FFFE;
        end
        for (int m = 0; m < N_MICS; m++) begin
            for (int b = 0; b < N_BINS; b++) begin
                d = 48'((b + 1) * (b + 1) + m * m);
                if (mode == 1 && m == 0 && b == 0) d = 48'h8000_0000_0000;
                if (mode == 1 && m == 0 && b == 1) d = 48'h3FFF_FF00_0001;
                if (mode == 1 && m == 0 && b == 2) d = 48'd5;
                exp_q.push_back({b == N_BINS - 1, 3'(m), 8'(b), d});
            end
        end
    endtask

    task automatic check_reset_outputs(input string where);
        check_eq({where, "_tvalid"}, 64'(m_axis_tvalid), 64'(0));
        check_eq({where, "_tdata"},  64'(m_axis_tdata),  64'(0));
        check_eq({where, "_tuser"},  64'(m_axis_tuser),  64'(0));
        check_eq({where, "_tlast"},  64'(m_axis_tlast),  64'(0));
        check_eq({where, "_busy"},   64'(busy),          64'(0));
        check_eq({where, "_done"},   64'(frame_done),    64'(0));
        check_eq({where, "_overrun"},64'(overrun),       64'(0));
        check_eq({where, "_en"},     64'(bram_en),       64'(0));
        check_eq({where, "_addr"},   64'(bram_addr),     64'(0));
        check_eq({where, "_bram_rst"}, 64'(bram_rst),    64'(1));
    endtask

    // Runs one frame. rdy_pct: tready duty in percent; dup_cyc: cycle of an
    // extra frame_start (-1 none); reset_at: beat count at which reset is
    // asserted (0 none); start_at_done: pulse frame_start with frame_done.
    task automatic run_frame(input int mode, input int rdy_pct, input int dup_cyc,
                             input int reset_at, input bit start_at_done, input bit timing);
        int cyc, n_issue, n_beats, n_done, first_v, last_beat, done_cyc, max_out;
        bit prev_stall, busy_at_done, ovr_at_done;
        logic [59:0] prev_beat, cur_beat;
        n_issue = 0; n_beats = 0; n_done = 0; first_v = -1; last_beat = -1;
        done_cyc = -1; max_out = 0; prev_stall = 0; busy_at_done = 1; ovr_at_done = 1;
        prev_beat = '0;
        load_frame(mode);

        @(posedge clk); #1;
        frame_start = 1'b1;               // cycle 0
        @(posedge clk); #1;
        cyc = 1;
        while (1) begin
            frame_start = 1'b0;
            if (reset_at > 0 && n_beats >= reset_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("reset_reached_beat", 64'(n_beats), 64'(reset_at));
                check_reset_outputs("midreset");
                exp_q.delete();
                return;
            end
            if (timing && cyc == 1) begin
                check_eq("busy_cycle1", 64'(busy), 64'(1));
                check_eq("en_cycle1",   64'(bram_en), 64'(1));
            end
            if (bram_en) begin
                check_eq("addr", 64'(bram_addr),
                         64'(((n_issue % N_BINS) * N_MICS + n_issue / N_BINS) * 4));
                n_issue++;
            end
            if (n_issue - n_beats > max_out) max_out = n_issue - n_beats;
            if (m_axis_tvalid && first_v < 0) first_v = cyc;
            if (prev_stall)
                check_eq("hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}),
                         64'({1'b1, prev_beat}));
            m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
            cur_beat = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) check_eq("extra_beat", 64'(1), 64'(0));
                else                   check_eq("beat", 64'(cur_beat), 64'(exp_q.pop_front()));
                n_beats++;
                last_beat = cyc;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = cur_beat;
            if (frame_done) begin
                n_done++;
                done_cyc     = cyc;
                busy_at_done = busy;
                ovr_at_done  = overrun;
                if (start_at_done) frame_start = 1'b1;
            end
            if (cyc == dup_cyc) frame_start = 1'b1;
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
            if (cyc >= 15000) begin
                check_eq("timeout", 64'(1), 64'(0));
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        m_axis_tready = 1'b0;

        check_eq("beats",      64'(n_beats), 64'(N_BEATS));
        check_eq("issues",     64'(n_issue), 64'(N_BEATS));
        check_eq("exp_left",   64'(exp_q.size()), 64'(0));
        check_eq("done_count", 64'(n_done), 64'(1));
        check_eq("done_after_last", 64'(done_cyc), 64'(last_beat + 1));
        check_eq("busy_at_done", 64'(busy_at_done), 64'(0));
        check_eq("first_tvalid", 64'(first_v), 64'(RD_LAT + 4));
        check_eq("outstanding_le_depth", 64'(max_out <= FIFO_DEPTH), 64'(1));
        if (timing) begin
            check_eq("last_beat_cycle", 64'(last_beat), 64'(N_BEATS + RD_LAT + 3));
            check_eq("done_cycle",      64'(done_cyc),  64'(N_BEATS + RD_LAT + 4));
        end
        if (start_at_done) begin
            check_eq("ovr_before_done_start", 64'(ovr_at_done), 64'(0));
            check_eq("ovr_after_done_start",  64'(overrun), 64'(1));
            check_eq("idle_after_done_start", 64'(busy), 64'(0));
        end else begin
            check_eq("overrun", 64'(overrun), 64'(dup_cyc >= 0));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int idle_hits;
        rst_n = 1'b0;
        frame_start = 1'b0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            rd_re[i] = '0;
            rd_im[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        #1;
        check_eq("bram_rst_released", 64'(bram_rst), 64'(0));

        run_frame(0, 100, -1, 0, 1'b0, 1'b1);   // ramp data, tready high
        run_frame(1, 100, -1, 0, 1'b0, 1'b1);   // corner values
        run_frame(0, 30,  -1, 0, 1'b0, 1'b0);   // sparse tready
        run_frame(0, 100, 300, 0, 1'b0, 1'b1);  // frame_start while busy

        run_frame(0, 100, -1, 700, 1'b0, 1'b0); // reset mid-frame
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle_hits = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (m_axis_tvalid || frame_done || bram_en || busy) idle_hits++;
        end
        check_eq("idle_after_reset", 64'(idle_hits), 64'(0));

        run_frame(0, 100, -1, 0, 1'b1, 1'b1);   // full frame after reset

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
